// File: rtl/rv32_pkg.sv
// Shared opcode/funct3 constants, FSM state encoding and immediate decoders
// for the rv32 memory core.
package rv32_pkg;

    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] F3_ADDI = 3'b000;
    localparam logic [2:0] F3_B    = 3'b000;
    localparam logic [2:0] F3_H    = 3'b001;
    localparam logic [2:0] F3_W    = 3'b010;
    localparam logic [2:0] F3_BU   = 3'b100;
    localparam logic [2:0] F3_HU   = 3'b101;

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_EXEC  = 3'd1,
        S_MEM   = 3'd2,
        S_HALT  = 3'd3,
        S_TRAP  = 3'd4
    } state_t;

    // Callers pass only the instruction bits each format uses.
    function automatic logic [31:0] i_imm(input logic [11:0] f);
        return {{20{f[11]}}, f};
    endfunction

    function automatic logic [31:0] s_imm(input logic [6:0] hi, input logic [4:0] lo);
        return {{20{hi[6]}}, hi, lo};
    endfunction

    function automatic logic [31:0] u_imm(input logic [19:0] f);
        return {f, 12'b0};
    endfunction

    // f is ir[31:12]
    function automatic logic [31:0] j_imm(input logic [19:0] f);
        return {{11{f[19]}}, f[19], f[7:0], f[8], f[18:9], 1'b0};
    endfunction

endpackage

// File: rtl/rv32_lsu_align.sv
// Combinational load lane extraction/extension, store byte-enable and data
// shifting, and the natural-alignment check for both.
module rv32_lsu_align
    import rv32_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  ea_lo_i,
    input  logic [31:0] rdata_i,
    input  logic [31:0] sdata_i,
    output logic [31:0] ldata_o,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic        misaligned_o
);

    logic [31:0] shifted;

    always_comb begin
        shifted      = rdata_i >> {ea_lo_i, 3'b000};
        ldata_o      = shifted;
        be_o         = 4'b0000;
        wdata_o      = sdata_i << {ea_lo_i, 3'b000};
        misaligned_o = 1'b0;
        case (funct3_i)
            F3_B: begin
                ldata_o = {{24{shifted[7]}}, shifted[7:0]};
                be_o    = 4'b0001 << ea_lo_i;
            end
            F3_BU: ldata_o = {24'b0, shifted[7:0]};
            F3_H: begin
                ldata_o      = {{16{shifted[15]}}, shifted[15:0]};
                be_o         = 4'b0011 << {ea_lo_i[1], 1'b0};
                misaligned_o = ea_lo_i[0];
            end
            F3_HU: begin
                ldata_o      = {16'b0, shifted[15:0]};
                misaligned_o = ea_lo_i[0];
            end
            F3_W: begin
                ldata_o      = rdata_i;
                be_o         = 4'b1111;
                misaligned_o = |ea_lo_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/rv32_mem_core.sv
// Multi-cycle RV32 subset core (FETCH/EXEC/MEM) over one unified word memory,
// stopping in HALT on JAL-to-self or TRAP on any exception.
module rv32_mem_core
    import rv32_pkg::*;
#(
    parameter int          MEM_WORDS  = 1024,
    parameter logic [31:0] RESET_PC   = 32'h0,
    parameter int          RESULT_REG = 7,
    parameter logic [31:0] EXPECTED   = 32'd1337,
    parameter int          BLINK_BIT  = 20,
    parameter string       INIT_FILE  = ""
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        finished,
    output logic        trapped,
    output logic [31:0] result,
    output logic [31:0] trap_pc,
    output logic        led_done
);

    localparam int         AW      = $clog2(MEM_WORDS);
    localparam logic [4:0] RES_IDX = 5'(RESULT_REG);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] result_q, result_d;
    logic [31:0] trap_pc_q, trap_pc_d;
    logic [25:0] blink_q;
    logic        led_q, led_d;
    logic [31:0] x_q [32];
    logic [31:0] ir_q, mdr_q;
    logic [31:0] mem_q [MEM_WORDS] = '{default: '0};

    logic [6:0]    opcode;
    logic [4:0]    rd, rs1, rs2;
    logic [2:0]    f3;
    logic [31:0]   rs1_v, rs2_v, res_v;
    logic [31:0]   imm_i, imm_s, imm_u, imm_j, ea, jal_tgt;
    logic          ea_oob, ld_f3_ok, st_f3_ok;
    logic [AW-1:0] mem_addr;
    logic [31:0]   ld_data, st_wdata;
    logic [3:0]    st_be;
    logic          misal;
    logic          rf_we, mem_we, do_trap, do_halt;
    logic [31:0]   rf_wdata;

    assign opcode   = ir_q[6:0];
    assign rd       = ir_q[11:7];
    assign f3       = ir_q[14:12];
    assign rs1      = ir_q[19:15];
    assign rs2      = ir_q[24:20];
    assign rs1_v    = (rs1 == 5'd0) ? '0 : x_q[rs1];
    assign rs2_v    = (rs2 == 5'd0) ? '0 : x_q[rs2];
    assign res_v    = (RES_IDX == 5'd0) ? '0 : x_q[RES_IDX];
    assign imm_i    = i_imm(ir_q[31:20]);
    assign imm_s    = s_imm(ir_q[31:25], ir_q[11:7]);
    assign imm_u    = u_imm(ir_q[31:12]);
    assign imm_j    = j_imm(ir_q[31:12]);
    // ea is recomputed in MEM; rs1 cannot change between EXEC and MEM.
    assign ea       = rs1_v + ((opcode == OP_STORE) ? imm_s : imm_i);
    assign ea_oob   = {2'b00, ea[31:2]} >= 32'(MEM_WORDS);
    assign ld_f3_ok = f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    assign st_f3_ok = f3 inside {F3_B, F3_H, F3_W};
    assign jal_tgt  = pc_q + imm_j;
    assign mem_addr = (state_q == S_FETCH) ? pc_q[AW+1:2] : ea[AW+1:2];

    rv32_lsu_align u_lsu (
        .funct3_i     (f3),
        .ea_lo_i      (ea[1:0]),
        .rdata_i      (mdr_q),
        .sdata_i      (rs2_v),
        .ldata_o      (ld_data),
        .be_o         (st_be),
        .wdata_o      (st_wdata),
        .misaligned_o (misal)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        result_d  = result_q;
        trap_pc_d = trap_pc_q;
        rf_we     = 1'b0;
        rf_wdata  = '0;
        mem_we    = 1'b0;
        do_trap   = 1'b0;
        do_halt   = 1'b0;
        case (state_q)
            S_FETCH: state_d = S_EXEC;
            S_EXEC: begin
                state_d = S_FETCH;
                pc_d    = pc_q + 32'd4;
                case (opcode)
                    OP_IMM: begin
                        if (f3 == F3_ADDI) begin
                            rf_we    = 1'b1;
                            rf_wdata = rs1_v + imm_i;
                        end else begin
                            do_trap = 1'b1;
                        end
                    end
                    OP_LUI: begin
                        rf_we    = 1'b1;
                        rf_wdata = imm_u;
                    end
                    OP_AUIPC: begin
                        rf_we    = 1'b1;
                        rf_wdata = pc_q + imm_u;
                    end
                    OP_JAL: begin
                        if (imm_j == 32'd0) begin
                            do_halt = 1'b1;
                        end else if (jal_tgt[1:0] != 2'b00) begin
                            do_trap = 1'b1;
                        end else begin
                            rf_we    = 1'b1;
                            rf_wdata = pc_q + 32'd4;
                            pc_d     = jal_tgt;
                        end
                    end
                    OP_LOAD: begin
                        if (!ld_f3_ok || misal || ea_oob) begin
                            do_trap = 1'b1;
                        end else begin
                            state_d = S_MEM;
                            pc_d    = pc_q;
                        end
                    end
                    OP_STORE: begin
                        if (!st_f3_ok || misal || ea_oob) do_trap = 1'b1;
                        // A reset landing on this edge must suppress the write.
                        else mem_we = i_rst_n;
                    end
                    default: do_trap = 1'b1;
                endcase
                if (do_trap) begin
                    state_d   = S_TRAP;
                    pc_d      = pc_q;
                    trap_pc_d = pc_q;
                    result_d  = res_v;
                    rf_we     = 1'b0;
                end else if (do_halt) begin
                    state_d  = S_HALT;
                    pc_d     = pc_q;
                    result_d = res_v;
                end
            end
            S_MEM: begin
                rf_we    = 1'b1;
                rf_wdata = ld_data;
                pc_d     = pc_q + 32'd4;
                state_d  = S_FETCH;
            end
            default: ;
        endcase
    end

    assign led_d = (state_q == S_HALT) ? (result_q == EXPECTED) :
                   (state_q == S_TRAP) ? 1'b0 : blink_q[BLINK_BIT];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            result_q  <= '0;
            trap_pc_q <= '0;
            blink_q   <= '0;
            led_q     <= 1'b0;
            for (int i = 0; i < 32; i++) x_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            result_q  <= result_d;
            trap_pc_q <= trap_pc_d;
            blink_q   <= blink_q + 26'd1;
            led_q     <= led_d;
            if (rf_we && rd != 5'd0) x_q[rd] <= rf_wdata;
        end
    end

    // Single-port memory: instruction read in FETCH, data read/write in EXEC.
    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (st_be[b]) mem_q[mem_addr][8*b +: 8] <= st_wdata[8*b +: 8];
            end
        end
        if (state_q == S_FETCH) ir_q <= mem_q[mem_addr];
        else                    mdr_q <= mem_q[mem_addr];
    end

    assign finished = (state_q == S_HALT);
    assign trapped  = (state_q == S_TRAP);
    assign result   = result_q;
    assign trap_pc  = trap_pc_q;
    assign led_done = led_q;

endmodule
